// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage types and constants
package mips_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_e;

    localparam logic [31:0] PC_INC   = 32'd4;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - 2-entry buffer between fetch and decode
//  clk, rst_n : clock, async active-low reset
//  push, din  : enqueue din at the tail
//  pop        : drop the head entry
//  clear      : empty the buffer; overrides push/pop in the same cycle
//  dout       : head entry (registered storage, no bypass)
//  count      : number of valid entries, 0..2
module fetch_fifo
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [2];
    logic         head_q;
    logic         tail_q;
    logic [1:0]   count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            count_q  <= 2'd0;
        end else if (clear) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                mem_q[tail_q] <= din;
                tail_q        <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout  = mem_q[head_q];
    assign count = count_q;

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: PC, ROM address, decode buffer
//  clk, rst_n               : clock, async active-low reset
//  rom_address / rom_data   : combinational program ROM interface (address = pc_q)
//  br_req / br_target       : branch redirect
//  exc_req / exc_target     : exception/eret redirect, wins over branch
//  id_ready                 : decode accepts the head entry
//  if_valid/if_pc/if_inst/if_adel : head entry of the decode buffer
module inst_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rom_address,
    input  logic [31:0] rom_data,
    input  logic        br_req,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic [31:0] exc_target,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_adel
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         redirect;
    logic         misaligned;
    logic         push;
    logic         pop;
    logic [1:0]   count;
    fetch_entry_t din;
    fetch_entry_t dout;

    assign redirect   = exc_req | br_req;
    assign misaligned = pc_q[1:0] != 2'b00;
    assign pop        = if_valid & id_ready;
    // Space exists if not full, or the head leaves this same cycle.
    assign push = (state_q == FETCH) & ((count < 2'(FIFO_DEPTH)) | pop) & ~redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        din     = '{pc: pc_q, inst: rom_data, adel: 1'b0};
        if (misaligned) begin
            // The ROM word at a misaligned address is meaningless; hand a NOP.
            din = '{pc: pc_q, inst: NOP_INST, adel: 1'b1};
        end
        if (redirect) begin
            pc_d    = exc_req ? exc_target : br_target;
            state_d = FETCH;
        end else if (push) begin
            if (misaligned) begin
                state_d = HALT;
            end else begin
                pc_d = pc_q + PC_INC;
            end
        end
    end

    fetch_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (redirect),
        .din   (din),
        .dout  (dout),
        .count (count)
    );

    assign rom_address = pc_q;
    assign if_valid    = count != 2'd0;
    assign if_pc       = dout.pc;
    assign if_inst     = dout.inst;
    assign if_adel     = dout.adel;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch with a queue reference model
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } exp_entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rom_address;
    logic [31:0] rom_data;
    logic        br_req;
    logic [31:0] br_target;
    logic        exc_req;
    logic [31:0] exc_target;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adel;

    int checks = 0;
    int errors = 0;

    exp_entry_t  exp_q[$];
    logic [31:0] m_pc;
    logic        m_halt;

    inst_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_address (rom_address),
        .rom_data    (rom_data),
        .br_req      (br_req),
        .br_target   (br_target),
        .exc_req     (exc_req),
        .exc_target  (exc_target),
        .id_ready    (id_ready),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .if_adel     (if_adel)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign rom_data = rom_word(rom_address);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pc   = RESET_PC;
        m_halt = 1'b0;
    endtask

    // One clock cycle: apply inputs, compare at the falling edge, advance the model,
    // then leave the bench just past the rising edge.
    task automatic step(input logic rdy, input logic br, input logic [31:0] bt,
                        input logic exc, input logic [31:0] et);
        logic       pop;
        int         sz;
        exp_entry_t e;
        id_ready   = rdy;
        br_req     = br;
        br_target  = bt;
        exc_req    = exc;
        exc_target = et;
        @(negedge clk);
        check("rom_address", rom_address, m_pc);
        check("if_valid", {31'd0, if_valid}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            check("if_pc", if_pc, exp_q[0].pc);
            check("if_inst", if_inst, exp_q[0].inst);
            check("if_adel", {31'd0, if_adel}, {31'd0, exp_q[0].adel});
        end
        pop = (exp_q.size() != 0) && rdy;
        sz  = exp_q.size();
        if (exc || br) begin
            exp_q.delete();
            m_pc   = exc ? et : bt;
            m_halt = 1'b0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (!m_halt && (sz < 2 || pop)) begin
                if (m_pc[1:0] != 2'b00) begin
                    e = '{pc: m_pc, inst: 32'h0, adel: 1'b1};
                    m_halt = 1'b1;
                end else begin
                    e = '{pc: m_pc, inst: rom_word(m_pc), adel: 1'b0};
                    m_pc = m_pc + 32'd4;
                end
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(rdy, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("rst if_valid", {31'd0, if_valid}, 32'd0);
        check("rst if_pc", if_pc, 32'd0);
        check("rst if_inst", if_inst, 32'd0);
        check("rst if_adel", {31'd0, if_adel}, 32'd0);
        check("rst rom_address", rom_address, RESET_PC);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic        r_rdy;
        logic        r_br;
        logic        r_exc;
        logic [31:0] r_bt;
        logic [31:0] r_et;

        rst_n      = 1'b0;
        id_ready   = 1'b0;
        br_req     = 1'b0;
        br_target  = 32'h0;
        exc_req    = 1'b0;
        exc_target = 32'h0;
        model_reset();
        @(posedge clk);
        #1;
        pulse_reset();

        // Streaming with decode always ready.
        run(8, 1'b1);

        // Two fetches then stall; buffer saturates with rom_address held at 8.
        pulse_reset();
        run(2, 1'b0);
        check("stall rom_address", rom_address, 32'h8);
        run(5, 1'b0);
        check("stall held pc", rom_address, 32'h8);
        check("stall head pc", if_pc, 32'h0);
        run(6, 1'b1);

        // Branch while full.
        run(3, 1'b0);
        step(1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("branch target", if_pc, 32'h40);
        run(4, 1'b1);

        // Exception beats branch in the same cycle.
        step(1'b1, 1'b1, 32'h40, 1'b1, 32'h180);
        check("exc wins", rom_address, 32'h180);
        run(4, 1'b1);

        // Misaligned target: one error entry, then silence until the next redirect.
        step(1'b1, 1'b1, 32'h42, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("adel flag", {31'd0, if_adel}, 32'd1);
        run(5, 1'b1);
        check("halt no valid", {31'd0, if_valid}, 32'd0);
        step(1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
        run(4, 1'b1);

        // PC wrap, then reset in the middle of the stream.
        step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        run(3, 1'b1);
        pulse_reset();
        run(4, 1'b1);

        // Randomized traffic with occasional redirects, some misaligned.
        for (int i = 0; i < 400; i++) begin
            r_rdy = $urandom_range(0, 3) != 0;
            r_br  = $urandom_range(0, 15) == 0;
            r_exc = $urandom_range(0, 31) == 0;
            r_bt  = $urandom & 32'h0000_FFFF;
            r_et  = $urandom & 32'h0000_FFFF;
            if ($urandom_range(0, 3) != 0) r_bt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) r_et[1:0] = 2'b00;
            step(r_rdy, r_br, r_bt, r_exc, r_et);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
